regc_enable_seq: RTL and testbench



---
 rtl/regc_pkg.sv | 22 ++
 rtl/regc_enable_seq_if.sv | 22 ++
 rtl/regc_vgood_filt.sv | 55 +++++
 rtl/regc_enable_seq.sv | 110 +++++++++++
 tb/tb_regc_enable_seq.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regc_pkg.sv
// Shared types and defaults for the 1.8 V regulator enable sequencer.
package regc_pkg;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_RAMP  = 3'd1,
        ST_ON    = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FAULT = 3'd4
    } regc_state_e;

    localparam int RAMP_DEF  = 1000;
    localparam int DRAIN_DEF = 200;
    localparam int DGL_DEF   = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/regc_enable_seq_if.sv
// Control/status bundle between the housekeeping side, the regulator macro
// and the enable sequencer.
interface regc_enable_seq_if;
    logic       req;
    logic       vgood;
    logic       fault_clr;
    logic       reg_en;
    logic       reg_enb;
    logic       ready;
    logic       fault;
    logic [2:0] state;

    modport master (
        output req, vgood, fault_clr,
        input  reg_en, reg_enb, ready, fault, state
    );

    modport slave (
        input  req, vgood, fault_clr,
        output reg_en, reg_enb, ready, fault, state
    );
endinterface

// File: rtl/regc_vgood_filt.sv
// vgood conditioning: 2-flop synchronizer, plus an optional deglitch filter
// enabled by the macro REGC_SEQ_VGOOD_DEGLITCH_EN.
module regc_vgood_filt
`ifdef REGC_SEQ_VGOOD_DEGLITCH_EN
#(
    parameter int DGL_CYCLES = regc_pkg::DGL_DEF
)
`endif
(
    input  logic clk,
    input  logic resetn,
    input  logic vgood,
    output logic vgood_f
);

    logic sync_1;
    logic vgood_s;

    // Bring the asynchronous comparator output into the clk domain.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_1  <= 1'b0;
            vgood_s <= 1'b0;
        end else begin
            sync_1  <= vgood;
            vgood_s <= sync_1;
        end
    end

`ifdef REGC_SEQ_VGOOD_DEGLITCH_EN
    localparam int DW = $clog2(DGL_CYCLES + 1);

    logic [DW-1:0] run;

    // Flip the filtered level only after DGL_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run     <= '0;
            vgood_f <= 1'b0;
        end else if (vgood_s != vgood_f) begin
            if (run == DW'(DGL_CYCLES - 1)) begin
                vgood_f <= vgood_s;
                run     <= '0;
            end else begin
                run <= run + 1'b1;
            end
        end else begin
            run <= '0;
        end
    end
`else
    assign vgood_f = vgood_s;
`endif

endmodule

// File: rtl/regc_enable_seq.sv
// Regulator enable sequencer: OFF -> RAMP -> ON, brown-out to FAULT, timed
// DRAIN before OFF is re-entered. Optional vgood deglitch is selected by the
// macro REGC_SEQ_VGOOD_DEGLITCH_EN (default build: synchronizer only).
module regc_enable_seq
    import regc_pkg::*;
#(
    parameter int RAMP_CYCLES  = RAMP_DEF,
    parameter int DRAIN_CYCLES = DRAIN_DEF,
    parameter int DGL_CYCLES   = DGL_DEF
)
(
    input  logic          clk,
    input  logic          resetn,
    regc_enable_seq_if.slave bus
);

    localparam int CNT_W = $clog2(max3(RAMP_CYCLES, DRAIN_CYCLES, DGL_CYCLES) + 1);

    regc_state_e      st;
    regc_state_e      st_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             en_nxt;
    logic             vgood_f;

    regc_vgood_filt
`ifdef REGC_SEQ_VGOOD_DEGLITCH_EN
        #(.DGL_CYCLES(DGL_CYCLES))
`endif
        u_filt (
            .clk     (clk),
            .resetn  (resetn),
            .vgood   (bus.vgood),
            .vgood_f (vgood_f)
        );

    // Next-state and counter decode; the counter is only loaded on entry to
    // RAMP/DRAIN and parked at zero elsewhere, so it can never wrap.
    always_comb begin
        st_nxt  = st;
        cnt_nxt = '0;
        case (st)
            ST_OFF: begin
                if (bus.req) begin
                    st_nxt  = ST_RAMP;
                    cnt_nxt = CNT_W'(RAMP_CYCLES - 1);
                end
            end
            ST_RAMP: begin
                if (!bus.req) begin
                    st_nxt  = ST_DRAIN;
                    cnt_nxt = CNT_W'(DRAIN_CYCLES - 1);
                end else if (cnt == '0) begin
                    st_nxt = vgood_f ? ST_ON : ST_FAULT;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_ON: begin
                if (!vgood_f) begin
                    st_nxt = ST_FAULT;
                end else if (!bus.req) begin
                    st_nxt  = ST_DRAIN;
                    cnt_nxt = CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                if (cnt == '0) begin
                    st_nxt = ST_OFF;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_FAULT: begin
                if (bus.fault_clr) begin
                    st_nxt  = ST_DRAIN;
                    cnt_nxt = CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            default: begin
                st_nxt = ST_OFF;
            end
        endcase
        en_nxt = (st_nxt == ST_RAMP) || (st_nxt == ST_ON);
    end

    // State, counter and registered outputs; EN/ENB share one decode so they
    // are always complementary. ready rises after the first full cycle in ON
    // and falls on the edge that leaves ON.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st          <= ST_OFF;
            cnt         <= '0;
            bus.reg_en  <= 1'b0;
            bus.reg_enb <= 1'b1;
            bus.ready   <= 1'b0;
            bus.fault   <= 1'b0;
        end else begin
            st          <= st_nxt;
            cnt         <= cnt_nxt;
            bus.reg_en  <= en_nxt;
            bus.reg_enb <= ~en_nxt;
            bus.ready   <= (st == ST_ON) && (st_nxt == ST_ON);
            bus.fault   <= (st_nxt == ST_FAULT);
        end
    end

    assign bus.state = st;

endmodule

// File: tb/tb_regc_enable_seq.sv
// Bench for regc_enable_seq with RAMP=8, DRAIN=4, DGL=3, checked against a
// cycle-level behavioural model of the sequencing rules.
module tb_regc_enable_seq;

    localparam int RAMP_C  = 8;
    localparam int DRAIN_C = 4;
    localparam int DGL_C   = 3;

    localparam int M_OFF   = 0;
    localparam int M_RAMP  = 1;
    localparam int M_ON    = 2;
    localparam int M_DRAIN = 3;
    localparam int M_FAULT = 4;

`ifdef REGC_SEQ_VGOOD_DEGLITCH_EN
    localparam int VG_LAT = 2 + DGL_C;
`else
    localparam int VG_LAT = 2;
`endif

    logic clk;
    logic resetn;
    int   vectors;
    int   miscompares;

    regc_enable_seq_if bus();

    regc_enable_seq #(
        .RAMP_CYCLES  (RAMP_C),
        .DRAIN_CYCLES (DRAIN_C),
        .DGL_CYCLES   (DGL_C)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    logic [6:0] act;
    assign act = {bus.reg_en, bus.reg_enb, bus.ready, bus.fault, bus.state};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int   m_mode;
    int   m_k;      // edges spent in the current mode
    int   m_run;
    logic m_s1;
    logic m_s2;
    logic m_filt;

    task automatic model_reset();
        m_mode = M_OFF;
        m_k    = 0;
        m_run  = 0;
        m_s1   = 1'b0;
        m_s2   = 1'b0;
        m_filt = 1'b0;
    endtask

    task automatic model_step();
        int   nm;
        logic vf;
`ifdef REGC_SEQ_VGOOD_DEGLITCH_EN
        vf = m_filt;
`else
        vf = m_s2;
`endif
        nm = m_mode;
        case (m_mode)
            M_OFF:   if (bus.req) nm = M_RAMP;
            M_RAMP: begin
                m_k++;
                if (!bus.req) nm = M_DRAIN;
                else if (m_k == RAMP_C) nm = vf ? M_ON : M_FAULT;
            end
            M_ON: begin
                m_k++;
                if (!vf) nm = M_FAULT;
                else if (!bus.req) nm = M_DRAIN;
            end
            M_DRAIN: begin
                m_k++;
                if (m_k == DRAIN_C) nm = M_OFF;
            end
            default: if (bus.fault_clr) nm = M_DRAIN;
        endcase
        if (nm != m_mode) m_k = 0;
        m_mode = nm;
`ifdef REGC_SEQ_VGOOD_DEGLITCH_EN
        if (m_s2 !== m_filt) begin
            m_run++;
            if (m_run == DGL_C) begin
                m_filt = m_s2;
                m_run  = 0;
            end
        end else begin
            m_run = 0;
        end
`endif
        m_s2 = m_s1;
        m_s1 = bus.vgood;
    endtask

    function automatic logic [6:0] exp_vec();
        logic en;
        en = (m_mode == M_RAMP) || (m_mode == M_ON);
        return {en, ~en, (m_mode == M_ON) && (m_k >= 1), m_mode == M_FAULT, 3'(m_mode)};
    endfunction

    // One clock: model follows the DUT edge, outputs settle for the negedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic reach_off(output bit ok);
        ok = 1'b0;
        if (bus.state == 3'd4) begin
            bus.fault_clr = 1'b1;
            tick();
            bus.fault_clr = 1'b0;
        end
        bus.req = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (bus.state == 3'd0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic reach_on(output bit ok);
        bit off_ok;
        reach_off(off_ok);
        bus.vgood = 1'b1;
        repeat (8) tick();
        bus.req = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (bus.ready) begin
                ok = off_ok;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn        = 1'b0;
        bus.req       = 1'b0;
        bus.vgood     = 1'b0;
        bus.fault_clr = 1'b0;
        model_reset();
        #23;
        vectors++;
        if (act !== 7'b0100000) begin
            miscompares++;
            $display("FAIL reset_values got=%b want=%b", act, 7'b0100000);
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if (bus.state !== 3'd0 || act !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, act, exp_vec());
            end
        end
    endtask

    task automatic test_power_up();
        int n;
        bus.vgood = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if (act !== exp_vec()) begin
                miscompares++;
                $display("FAIL pu_settle got=%b want=%b", act, exp_vec());
            end
        end
        bus.req = 1'b1;
        tick();
        vectors++;
        if (bus.reg_en !== 1'b1 || bus.reg_enb !== 1'b0) begin
            miscompares++;
            $display("FAIL pu_en_latency got en/enb=%b%b want=10", bus.reg_en, bus.reg_enb);
        end
        n = 0;
        while (n < 30 && bus.ready !== 1'b1) begin
            tick();
            n++;
            vectors++;
            if (act !== exp_vec()) begin
                miscompares++;
                $display("FAIL pu_ramp cyc=%0d got=%b want=%b", n, act, exp_vec());
            end
        end
        vectors++;
        if (n != RAMP_C + 1 || bus.state !== 3'd2) begin
            miscompares++;
            $display("FAIL pu_ready_latency got=%0d cycles state=%0d want=%0d cycles state=2",
                     n, bus.state, RAMP_C + 1);
        end
    endtask

    task automatic test_ramp_fail();
        bit ok;
        int n;
        int exp_seq [5] = '{3, 3, 3, 0, 1};
        reach_off(ok);
        bus.vgood = 1'b0;
        repeat (8) tick();
        bus.req = 1'b1;
        n = 0;
        while (n < 30 && bus.state !== 3'd4) begin
            tick();
            n++;
            vectors++;
            if (act !== exp_vec()) begin
                miscompares++;
                $display("FAIL rf_ramp cyc=%0d got=%b want=%b", n, act, exp_vec());
            end
        end
        vectors++;
        if (!ok || n != RAMP_C + 1 || bus.fault !== 1'b1 || bus.reg_en !== 1'b0 || bus.reg_enb !== 1'b1) begin
            miscompares++;
            $display("FAIL rf_fault got cycles=%0d fault=%b en=%b want cycles=%0d fault=1 en=0",
                     n, bus.fault, bus.reg_en, RAMP_C + 1);
        end
        bus.fault_clr = 1'b1;
        tick();
        bus.fault_clr = 1'b0;
        vectors++;
        if (bus.fault !== 1'b0 || bus.state !== 3'd3) begin
            miscompares++;
            $display("FAIL rf_clear got fault=%b state=%0d want fault=0 state=3", bus.fault, bus.state);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (bus.state !== 3'(exp_seq[i]) || act !== exp_vec()) begin
                miscompares++;
                $display("FAIL rf_drain_seq step=%0d got state=%0d want=%0d", i, bus.state, exp_seq[i]);
            end
        end
    endtask

    task automatic test_brown_out();
        bit ok;
        int n;
        reach_on(ok);
        bus.vgood = 1'b0;
        tick();
        bus.vgood = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (act !== exp_vec()) begin
                miscompares++;
                $display("FAIL bo_glitch cyc=%0d got=%b want=%b", i, act, exp_vec());
            end
        end
        vectors++;
`ifdef REGC_SEQ_VGOOD_DEGLITCH_EN
        if (!ok || bus.state !== 3'd2) begin
`else
        if (!ok || bus.state !== 3'd4) begin
`endif
            miscompares++;
            $display("FAIL bo_glitch_state got=%0d ok=%0d", bus.state, ok);
        end
        reach_on(ok);
        bus.vgood = 1'b0;
        n = 0;
        while (n < 30 && bus.state !== 3'd4) begin
            tick();
            n++;
            vectors++;
            if (act !== exp_vec()) begin
                miscompares++;
                $display("FAIL bo_long cyc=%0d got=%b want=%b", n, act, exp_vec());
            end
        end
        // the FSM reacts on the edge after the filtered level drops
        vectors++;
        if (!ok || n != VG_LAT + 1) begin
            miscompares++;
            $display("FAIL bo_latency got=%0d want=%0d", n, VG_LAT + 1);
        end
        bus.vgood = 1'b1;
    endtask

    task automatic test_abort();
        bit ok;
        reach_off(ok);
        bus.vgood = 1'b1;
        bus.req   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (bus.state !== 3'd1 || act !== exp_vec()) begin
                miscompares++;
                $display("FAIL ab_ramp cyc=%0d got=%b want=%b", i, act, exp_vec());
            end
        end
        bus.req = 1'b0;
        tick();
        vectors++;
        if (!ok || bus.state !== 3'd3 || bus.reg_en !== 1'b0 || bus.reg_enb !== 1'b1) begin
            miscompares++;
            $display("FAIL ab_drain got state=%0d en=%b want state=3 en=0", bus.state, bus.reg_en);
        end
    endtask

    task automatic test_priority();
        bit ok;
        reach_on(ok);
        bus.vgood = 1'b0;
        for (int i = 0; i < VG_LAT; i++) begin
            tick();
            vectors++;
            if (bus.state !== 3'd2 || act !== exp_vec()) begin
                miscompares++;
                $display("FAIL pr_hold cyc=%0d got=%b want=%b", i, act, exp_vec());
            end
        end
        bus.req = 1'b0;
        tick();
        vectors++;
        if (!ok || bus.state !== 3'd4 || act !== exp_vec()) begin
            miscompares++;
            $display("FAIL pr_fault got state=%0d want=4", bus.state);
        end
        bus.vgood = 1'b1;
    endtask

    task automatic test_async_reset();
        bit ok;
        reach_on(ok);
        #2;
        resetn = 1'b0;
        #1;
        vectors++;
        if (!ok || bus.reg_en !== 1'b0 || bus.reg_enb !== 1'b1 || bus.ready !== 1'b0 || bus.state !== 3'd0) begin
            miscompares++;
            $display("FAIL async_reset got en=%b enb=%b ready=%b state=%0d want 0 1 0 0",
                     bus.reg_en, bus.reg_enb, bus.ready, bus.state);
        end
        model_reset();
        bus.req = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_random();
        int vg_hold;
        vg_hold = 0;
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(15) == 0) bus.req = ~bus.req;
            if (vg_hold > 0) begin
                vg_hold--;
            end else begin
                bus.vgood = ($urandom_range(3) != 0);
                vg_hold   = $urandom_range(12);
            end
            bus.fault_clr = ($urandom_range(7) == 0);
            tick();
            vectors++;
            if (act !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%b want=%b", i, act, exp_vec());
            end
        end
        bus.fault_clr = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_power_up();
        test_ramp_fail();
        test_brown_out();
        test_abort();
        test_priority();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
